// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op/state encodings and default latencies for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;
endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational 32x32 multiply and divide producing the HI/LO result pair
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);
  logic [63:0] sprod, uprod;
  logic [31:0] ma, mb, dv, uq, ur, q, r;
  logic        na, nb;
  assign sprod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign uprod = {32'd0, a} * {32'd0, b};
  assign div_by_zero = (op == MD_DIV || op == MD_DIVU) && b == 32'd0;
  assign na = op == MD_DIV && a[31];
  assign nb = op == MD_DIV && b[31];
  assign ma = na ? -a : a;
  assign mb = nb ? -b : b;
  assign dv = div_by_zero ? 32'd1 : mb;
  assign uq = ma / dv;
  assign ur = ma % dv;
  assign q = (na ^ nb) ? -uq : uq;
  assign r = na ? -ur : ur;
  // select the HI/LO pair for the requested operation
  always_comb begin
    res_hi = op == MD_MULT ? sprod[63:32] : op == MD_MULTU ? uprod[63:32] : r;
    res_lo = op == MD_MULT ? sprod[31:0] : op == MD_MULTU ? uprod[31:0] : q;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequences mult/div through a fixed busy window and owns the HI/LO registers
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  state_t      state;
  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, pend_hi, pend_lo;
  logic        pend_dz, is_md, is_div;
  assign is_md = op == MD_MULT || op == MD_MULTU || op == MD_DIV || op == MD_DIVU;
  assign is_div = op == MD_DIV || op == MD_DIVU;
  mdu_arith u_arith (
    .op(op_q),
    .a(a_q),
    .b(b_q),
    .res_hi(pend_hi),
    .res_lo(pend_lo),
    .div_by_zero(pend_dz)
  );
  // latch operands on start, count down the busy window, commit on the final edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= 4'd0;
      op_q  <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else if (state == IDLE) begin
      if (start && is_md) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        cnt   <= is_div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
        state <= RUN;
        busy  <= 1'b1;
      end else if (start && op == MD_MTHI) begin
        hi <= a;
      end else if (start && op == MD_MTLO) begin
        lo <= a;
      end
    end else if (cnt == 4'd0) begin
      hi    <= pend_dz ? hi : pend_hi;
      lo    <= pend_dz ? lo : pend_lo;
      busy  <= 1'b0;
      state <= IDLE;
    end else begin
      cnt <= cnt - 4'd1;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for the multiply/divide sequencer
module tb_mdu_ctrl;
  import mdu_pkg::*;
  localparam int M = 5;
  localparam int D = 10;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0, b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;
  int          checks = 0, errors = 0, proto_err = 0;
  logic [63:0] sb[$];
  logic [31:0] sh_hi = 32'd0, sh_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(M), .DIV_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (start === 1'b1 && busy === 1'b1) begin
      proto_err++;
      $display("protocol error: start while busy at %0t", $time);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat(input logic [2:0] o);
    return (o == 3'd2 || o == 3'd3) ? D : M;
  endfunction

  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sp;
    logic signed [31:0] sq, sr;
    if (o == 3'd0) begin
      sp = $signed(x) * $signed(y);
      return sp;
    end
    if (o == 3'd1) return 64'(x) * 64'(y);
    if (y == 32'd0) return {sh_hi, sh_lo};
    if (o == 3'd3) return {x % y, x / y};
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sq = $signed(x) / $signed(y);
    sr = $signed(x) % $signed(y);
    return {sr, sq};
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
  endtask

  task automatic wait_commit(input int n, input int seen, input string name);
    int cyc = seen;
    bit moved = 0;
    logic [63:0] e;
    while (busy === 1'b1 && cyc < 40) begin
      if (hi !== sh_hi || lo !== sh_lo) moved = 1;
      cyc++;
      step();
    end
    checks++;
    if (cyc != n) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d exp %0d", name, cyc, n);
    end
    checks++;
    if (moved) begin
      errors++;
      $display("FAIL %s hilo_stable got changed exp unchanged", name);
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard got empty exp entry", name);
    end else begin
      e = sb.pop_front();
      if ({hi, lo} !== e) begin
        errors++;
        $display("FAIL %s hilo got %h_%h exp %h_%h", name, hi, lo, e[63:32], e[31:0]);
      end
      sh_hi = e[63:32];
      sh_lo = e[31:0];
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp_v, input string name);
    sb.push_back(exp_v);
    issue(o, x, y);
    wait_commit(lat(o), 0, name);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_mult();
    run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, "mult_neg");
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, "multu_max");
  endtask

  task automatic mt(input logic [31:0] h, input logic [31:0] l);
    start = 1'b1; op = MD_MTHI; a = h;
    step();
    checks += 2;
    if (hi !== h) begin errors++; $display("FAIL mthi got %h exp %h", hi, h); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mthi_busy got %b exp 0", busy); end
    op = MD_MTLO; a = l;
    step();
    start = 1'b0;
    checks += 3;
    if (lo !== l) begin errors++; $display("FAIL mtlo got %h exp %h", lo, l); end
    if (hi !== h) begin errors++; $display("FAIL mtlo_hi got %h exp %h", hi, h); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy got %b exp 0", busy); end
    sh_hi = h;
    sh_lo = l;
  endtask

  task automatic test_div();
    run_op(MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_neg");
    mt(32'h11, 32'h22);
    run_op(MD_DIVU, 32'd7, 32'd0, {32'h11, 32'h22}, "divu_zero");
    run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, "div_ovf");
  endtask

  task automatic test_undef();
    issue(3'd6, 32'hDEAD, 32'd1);
    step();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL undef_busy got %b exp 0", busy); end
    if ({hi, lo} !== {sh_hi, sh_lo}) begin
      errors++;
      $display("FAIL undef_hilo got %h_%h exp %h_%h", hi, lo, sh_hi, sh_lo);
    end
  endtask

  task automatic test_async_reset();
    bit bad = 0;
    mt(32'h1234, 32'h5678);
    issue(MD_MULT, 32'd3, 32'd4);
    step();
    step();
    #2 reset = 1'b1;
    #1;
    checks += 3;
    if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b exp 0", busy); end
    if (hi !== 32'd0) begin errors++; $display("FAIL areset_hi got %h exp 0", hi); end
    if (lo !== 32'd0) begin errors++; $display("FAIL areset_lo got %h exp 0", lo); end
    step();
    reset = 1'b0;
    sh_hi = 32'd0;
    sh_lo = 32'd0;
    repeat (8) begin
      step();
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL areset_no_commit got activity exp idle zero"); end
    run_op(MD_MULT, 32'd6, 32'd7, {32'd0, 32'd42}, "mult_after_reset");
  endtask

  task automatic test_start_while_run();
    bit bad = 0;
    sb.push_back({32'd2, 32'd14});
    issue(MD_DIV, 32'd100, 32'd7);
    step();
    issue(MD_MULT, 32'd5, 32'd5);
    wait_commit(D, 2, "div_ignore_mult");
    checks++;
    if (proto_err != 1) begin errors++; $display("FAIL proto_err got %0d exp 1", proto_err); end
    repeat (12) begin
      step();
      if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd14) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL ignored_mult got hilo %h_%h exp 00000002_0000000e", hi, lo); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (o >= 3'd2 && i % 2 == 1) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(o, x, y, model(o, x, y), "random");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_undef();
    test_async_reset();
    test_start_while_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
